// File: rtl/charge_req_arbiter.sv
// Round-robin arbiter that forwards one packet at a time from NUM_REQ requesters
// to a charging counter, dropping (and counting) zero-length packets.
module charge_req_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int LEN_W   = 16,
  parameter int CID_W   = 14,
  localparam int PTR_W  = $clog2(NUM_REQ)
) (
  input  logic                     asclk,
  input  logic                     areset,
  input  logic                     upd_en,
  input  logic [NUM_REQ-1:0]       req_vld,
  output logic [NUM_REQ-1:0]       req_rdy,
  input  logic [NUM_REQ*LEN_W-1:0] req_pkt_len,
  input  logic [NUM_REQ*CID_W-1:0] req_cnt_id,
  input  logic [NUM_REQ-1:0]       req_ul,
  output logic                     in_vld,
  input  logic                     in_rdy,
  output logic [LEN_W-1:0]         in_pkt_len,
  output logic [CID_W-1:0]         in_cnt_id,
  output logic                     in_ul,
  output logic                     in_cnt_en,
  output logic [PTR_W-1:0]         in_src,
  output logic [15:0]              drop_cnt,
  output logic                     dbg_state,
  output logic [PTR_W-1:0]         dbg_rr_ptr
);

  // Handshake: a packet moves when in_vld && in_rdy on a rising edge; req_rdy[k]
  // is a one-cycle accept pulse meaning requester k's packet is taken this edge.
  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t           state;
  logic [PTR_W-1:0] rr_ptr;
  logic             win_found;
  logic [PTR_W-1:0] win_idx;
  logic [PTR_W-1:0] cand_p;
  int               cand;
  logic             capture;
  logic [LEN_W-1:0] win_len;
  logic [CID_W-1:0] win_cid;
  logic [PTR_W-1:0] next_ptr;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_p    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = int'(rr_ptr) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_p = PTR_W'(cand);
      if (!win_found && req_vld[cand_p]) begin
        win_found = 1'b1;
        win_idx   = cand_p;
      end
    end
  end

  // A held packet's handshake frees the slot in the same cycle, enabling back-to-back.
  assign capture  = !areset && upd_en && ((state == IDLE) || in_rdy) && win_found;
  assign req_rdy  = capture ? (NUM_REQ'(1) << win_idx) : '0;
  assign win_len  = req_pkt_len[win_idx*LEN_W +: LEN_W];
  assign win_cid  = req_cnt_id[win_idx*CID_W +: CID_W];
  assign next_ptr = (win_idx == PTR_W'(NUM_REQ-1)) ? '0 : win_idx + 1'b1;

  always_ff @(posedge asclk) begin
    if (areset) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      in_vld     <= 1'b0;
      in_ul      <= 1'b0;
      in_src     <= '0;
      in_pkt_len <= '0;
      in_cnt_id  <= '0;
      drop_cnt   <= '0;
    end else if (capture) begin
      rr_ptr <= next_ptr;
      if (win_len != '0) begin
        state      <= HOLD;
        in_vld     <= 1'b1;
        in_pkt_len <= win_len;
        in_cnt_id  <= win_cid;
        in_ul      <= req_ul[win_idx];
        in_src     <= win_idx;
      end else begin
        // Zero-length packets are consumed here; any held packet just completed.
        state  <= IDLE;
        in_vld <= 1'b0;
        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end
    end else if ((state == HOLD) && in_rdy) begin
      state  <= IDLE;
      in_vld <= 1'b0;
    end
  end

  assign in_cnt_en  = in_vld;
  assign dbg_state  = (state == HOLD);
  assign dbg_rr_ptr = rr_ptr;

endmodule

// File: tb/tb_charge_req_arbiter.sv
// Directed table-driven bench for charge_req_arbiter with hand sequences for
// backpressure, reset mid-HOLD and drop counter saturation.
module tb_charge_req_arbiter;

  logic        asclk = 1'b0;
  logic        areset;
  logic        upd_en;
  logic [3:0]  req_vld;
  logic [3:0]  req_rdy;
  logic [63:0] req_pkt_len;
  logic [55:0] req_cnt_id;
  logic [3:0]  req_ul;
  logic        in_vld;
  logic        in_rdy;
  logic [15:0] in_pkt_len;
  logic [13:0] in_cnt_id;
  logic        in_ul;
  logic        in_cnt_en;
  logic [1:0]  in_src;
  logic [15:0] drop_cnt;
  logic        dbg_state;
  logic [1:0]  dbg_rr_ptr;

  logic [15:0] lens [4];
  int          errors = 0;
  int          checks = 0;

  typedef struct {
    logic [3:0]  vld;
    logic        upd;
    logic        rdy;
    logic [3:0]  zmask;
    logic [3:0]  e_rdy;
    logic        e_vld;
    logic [1:0]  e_src;
    logic [1:0]  e_rr;
    logic [15:0] e_drop;
  } vec_t;

  vec_t tbl[$];

  charge_req_arbiter #(.NUM_REQ(4), .LEN_W(16), .CID_W(14)) dut (
    .asclk(asclk), .areset(areset), .upd_en(upd_en), .req_vld(req_vld),
    .req_rdy(req_rdy), .req_pkt_len(req_pkt_len), .req_cnt_id(req_cnt_id),
    .req_ul(req_ul), .in_vld(in_vld), .in_rdy(in_rdy), .in_pkt_len(in_pkt_len),
    .in_cnt_id(in_cnt_id), .in_ul(in_ul), .in_cnt_en(in_cnt_en), .in_src(in_src),
    .drop_cnt(drop_cnt), .dbg_state(dbg_state), .dbg_rr_ptr(dbg_rr_ptr)
  );

  always #5 asclk = ~asclk;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      req_pkt_len[k*16 +: 16] = lens[k];
      req_cnt_id[k*14 +: 14]  = 14'h20 + 14'(k);
    end
  end
  assign req_ul = 4'b1010;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(logic [3:0] vld, logic upd, logic rdy, logic [3:0] zmask,
                              logic [3:0] e_rdy, logic e_vld, logic [1:0] e_src,
                              logic [1:0] e_rr, logic [15:0] e_drop);
    vec_t v;
    v.vld = vld; v.upd = upd; v.rdy = rdy; v.zmask = zmask; v.e_rdy = e_rdy;
    v.e_vld = e_vld; v.e_src = e_src; v.e_rr = e_rr; v.e_drop = e_drop;
    return v;
  endfunction

  task automatic set_lens(input logic [3:0] zmask);
    for (int k = 0; k < 4; k++) lens[k] = zmask[k] ? 16'h0 : 16'h100 + 16'(k);
  endtask

  task automatic drive(input logic [3:0] vld, input logic upd, input logic rdy);
    req_vld = vld; upd_en = upd; in_rdy = rdy;
  endtask

  task automatic check_fwd(input string name, input logic [1:0] src, input logic [15:0] len);
    chk({name, "_vld"}, {31'b0, in_vld}, 32'd1);
    chk({name, "_cnt_en"}, {31'b0, in_cnt_en}, 32'd1);
    chk({name, "_src"}, {30'b0, in_src}, {30'b0, src});
    chk({name, "_len"}, {16'b0, in_pkt_len}, {16'b0, len});
    chk({name, "_cid"}, {18'b0, in_cnt_id}, 32'h20 + {30'b0, src});
    chk({name, "_ul"}, {31'b0, in_ul}, {31'b0, src[0]});
  endtask

  initial begin
    areset = 1'b1;
    drive(4'b0000, 1'b1, 1'b1);
    set_lens(4'b0000);
    repeat (2) @(posedge asclk);
    #1;
    chk("rst_rdy", {28'b0, req_rdy}, 32'd0);
    chk("rst_vld", {31'b0, in_vld}, 32'd0);
    chk("rst_len", {16'b0, in_pkt_len}, 32'd0);
    chk("rst_drop", {16'b0, drop_cnt}, 32'd0);
    chk("rst_rr", {30'b0, dbg_rr_ptr}, 32'd0);
    areset = 1'b0;

    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(4'b1111, 1, 1, 4'b0, 4'(1 << (i % 4)), 1, 2'(i % 4), 2'((i + 1) % 4), 0));
    tbl.push_back(mk(4'b0000, 1, 1, 4'b0000, 4'b0000, 0, 0, 0, 0));
    tbl.push_back(mk(4'b0100, 1, 1, 4'b0000, 4'b0100, 1, 2, 3, 0));
    tbl.push_back(mk(4'b1001, 1, 1, 4'b0000, 4'b1000, 1, 3, 0, 0));
    tbl.push_back(mk(4'b1001, 1, 1, 4'b0000, 4'b0001, 1, 0, 1, 0));
    tbl.push_back(mk(4'b0000, 1, 1, 4'b0000, 4'b0000, 0, 0, 1, 0));
    tbl.push_back(mk(4'b0010, 1, 1, 4'b0010, 4'b0010, 0, 0, 2, 1));
    tbl.push_back(mk(4'b0010, 1, 1, 4'b0010, 4'b0010, 0, 0, 2, 2));
    tbl.push_back(mk(4'b0010, 1, 1, 4'b0010, 4'b0010, 0, 0, 2, 3));
    tbl.push_back(mk(4'b0001, 1, 1, 4'b0000, 4'b0001, 1, 0, 1, 3));
    tbl.push_back(mk(4'b0010, 1, 1, 4'b0010, 4'b0010, 0, 0, 2, 4));
    tbl.push_back(mk(4'b0100, 1, 1, 4'b0000, 4'b0100, 1, 2, 3, 4));
    tbl.push_back(mk(4'b0001, 0, 0, 4'b0000, 4'b0000, 1, 2, 3, 4));
    tbl.push_back(mk(4'b0001, 0, 1, 4'b0000, 4'b0000, 0, 0, 3, 4));
    tbl.push_back(mk(4'b0001, 0, 0, 4'b0000, 4'b0000, 0, 0, 3, 4));
    tbl.push_back(mk(4'b0001, 1, 1, 4'b0000, 4'b0001, 1, 0, 1, 4));
    tbl.push_back(mk(4'b0000, 1, 1, 4'b0000, 4'b0000, 0, 0, 1, 4));

    foreach (tbl[i]) begin
      set_lens(tbl[i].zmask);
      drive(tbl[i].vld, tbl[i].upd, tbl[i].rdy);
      #1;
      chk($sformatf("v%0d_req_rdy", i), {28'b0, req_rdy}, {28'b0, tbl[i].e_rdy});
      @(posedge asclk);
      #1;
      chk($sformatf("v%0d_in_vld", i), {31'b0, in_vld}, {31'b0, tbl[i].e_vld});
      chk($sformatf("v%0d_cnt_en", i), {31'b0, in_cnt_en}, {31'b0, tbl[i].e_vld});
      chk($sformatf("v%0d_state", i), {31'b0, dbg_state}, {31'b0, tbl[i].e_vld});
      chk($sformatf("v%0d_rr", i), {30'b0, dbg_rr_ptr}, {30'b0, tbl[i].e_rr});
      chk($sformatf("v%0d_drop", i), {16'b0, drop_cnt}, {16'b0, tbl[i].e_drop});
      if (tbl[i].e_vld)
        check_fwd($sformatf("v%0d", i), tbl[i].e_src, 16'h100 + 16'(tbl[i].e_src));
    end

    // Backpressure: src 2 with length 1024 held through five stalled cycles.
    set_lens(4'b0000);
    lens[2] = 16'd1024;
    drive(4'b0100, 1'b1, 1'b1);
    #1;
    chk("bp_grant", {28'b0, req_rdy}, 32'b0100);
    @(posedge asclk);
    #1;
    check_fwd("bp_cap", 2'd2, 16'd1024);
    drive(4'b0100, 1'b1, 1'b0);
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("bp_stall%0d_rdy", c), {28'b0, req_rdy}, 32'd0);
      @(posedge asclk);
      #1;
      check_fwd($sformatf("bp_stall%0d", c), 2'd2, 16'd1024);
    end
    drive(4'b0000, 1'b1, 1'b1);
    @(posedge asclk);
    #1;
    chk("bp_done_vld", {31'b0, in_vld}, 32'd0);
    chk("bp_done_state", {31'b0, dbg_state}, 32'd0);

    // Reset while a packet is held: no pulse, everything back to reset values.
    set_lens(4'b0000);
    drive(4'b1010, 1'b1, 1'b1);
    #1;
    chk("rh_grant", {28'b0, req_rdy}, 32'b1000);
    @(posedge asclk);
    #1;
    check_fwd("rh_cap", 2'd3, 16'h103);
    areset = 1'b1;
    drive(4'b1010, 1'b1, 1'b1);
    #1;
    chk("rh_rdy_in_reset", {28'b0, req_rdy}, 32'd0);
    @(posedge asclk);
    #1;
    areset = 1'b0;
    chk("rh_vld", {31'b0, in_vld}, 32'd0);
    chk("rh_cnt_en", {31'b0, in_cnt_en}, 32'd0);
    chk("rh_src", {30'b0, in_src}, 32'd0);
    chk("rh_ul", {31'b0, in_ul}, 32'd0);
    chk("rh_len", {16'b0, in_pkt_len}, 32'd0);
    chk("rh_cid", {18'b0, in_cnt_id}, 32'd0);
    chk("rh_rr", {30'b0, dbg_rr_ptr}, 32'd0);
    chk("rh_drop", {16'b0, drop_cnt}, 32'd0);
    #1;
    chk("rh_first_grant", {28'b0, req_rdy}, 32'b0010);
    @(posedge asclk);
    #1;
    check_fwd("rh_after", 2'd1, 16'h101);

    // Drop counter saturation from src 1 sending zero-length packets.
    lens[1] = 16'h0;
    drive(4'b0010, 1'b1, 1'b1);
    for (int c = 0; c < 70000; c++) begin
      @(posedge asclk);
      #1;
      if (drop_cnt == 16'hFFFF) break;
    end
    chk("sat_reach", {16'b0, drop_cnt}, 32'hFFFF);
    repeat (3) @(posedge asclk);
    #1;
    chk("sat_hold", {16'b0, drop_cnt}, 32'hFFFF);
    chk("sat_vld", {31'b0, in_vld}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
